// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control and a saturating match counter.
// Optional per-bit compare mask is enabled by defining SEQ_DET_MASK_EN (adds port cfg_mask).
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
`ifdef SEQ_DET_MASK_EN
    input  logic [MAX_LEN-1:0] cfg_mask,
`endif
    input  logic               in_valid,
    input  logic               in,
    output logic               detect,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat,
    output logic               armed
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_FILL     = 2'd1,
        ST_HUNT     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0] mask_q, mask_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               detect_q, detect_d;
    logic               sat_q, sat_d;
    logic               armed_q, armed_d;

    logic [MAX_LEN-1:0] window_s;
    logic [MAX_LEN-1:0] len_mask_s;
    logic               match_s;
    logic               cfg_legal_s;

    // Compare window: held history plus the incoming bit, restricted to the low len positions.
    always_comb begin
        window_s = {hist_q, in};
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask_s[i] = (LEN_W'(i) < len_q);
        end
        match_s = (state_q == ST_HUNT) && in_valid &&
                  (((window_s ^ pat_q) & len_mask_s & mask_q) == {MAX_LEN{1'b0}});
        cfg_legal_s = (cfg_len >= LEN_W'(1)) && (cfg_len <= LEN_W'(MAX_LEN));
    end

    // Next-state logic: cfg_load wins over a same-cycle valid bit, which is discarded.
    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        len_d    = len_q;
        pat_d    = pat_q;
        mask_d   = mask_q;
        ovl_d    = ovl_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        detect_d = 1'b0;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
`ifdef SEQ_DET_MASK_EN
            mask_d = cfg_mask;
`else
            mask_d = {MAX_LEN{1'b1}};
`endif
            hist_d = {(MAX_LEN-1){1'b0}};
            fill_d = {LEN_W{1'b0}};
            cnt_d  = {CNT_W{1'b0}};
            sat_d  = 1'b0;
            if (cfg_legal_s) begin
                state_d = (cfg_len == LEN_W'(1)) ? ST_HUNT : ST_FILL;
            end else begin
                state_d = ST_DISARMED;
            end
        end else if (in_valid && (state_q != ST_DISARMED)) begin
            hist_d = window_s[MAX_LEN-2:0];
            if (fill_q == LEN_W'(MAX_LEN)) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + LEN_W'(1);
            end
            case (state_q)
                ST_FILL: begin
                    if (fill_d >= (len_q - LEN_W'(1))) begin
                        state_d = ST_HUNT;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_HUNT: begin
                    if (match_s) begin
                        detect_d = 1'b1;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            cnt_d = cnt_q;
                        end
                        sat_d = (cnt_d == CNT_MAX);
                        // Non-overlap: the completing bit must not seed the next match.
                        if (!ovl_q) begin
                            fill_d  = {LEN_W{1'b0}};
                            state_d = (len_q == LEN_W'(1)) ? ST_HUNT : ST_FILL;
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                default: begin
                    state_d = ST_DISARMED;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        armed_d = (state_d != ST_DISARMED);
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_DISARMED;
            hist_q   <= {(MAX_LEN-1){1'b0}};
            fill_q   <= {LEN_W{1'b0}};
            len_q    <= {LEN_W{1'b0}};
            pat_q    <= {MAX_LEN{1'b0}};
            mask_q   <= {MAX_LEN{1'b0}};
            ovl_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            sat_q    <= 1'b0;
            detect_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            len_q    <= len_d;
            pat_q    <= pat_d;
            mask_q   <= mask_d;
            ovl_q    <= ovl_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            detect_q <= detect_d;
            armed_q  <= armed_d;
        end
    end

    assign detect      = detect_q;
    assign match_count = cnt_q;
    assign count_sat   = sat_q;
    assign armed       = armed_q;

endmodule
